// File: rtl/ifill_server.sv
// Instruction-cache line-fill server: queues line requests, bursts each line from
// backing memory one word per accepted read, and returns the words in order.
module ifill_server #(
  parameter int unsigned DEPTH      = 2,
  parameter int unsigned LINE_WORDS = 16
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        read_i,
  input  logic [15:0] addr_i,
  output logic        full_o,
  output logic        ready_o,
  output logic [31:0] data_o,
  output logic        mem_rd_o,
  output logic [15:0] mem_addr_o,
  input  logic        mem_wait_i,
  input  logic [31:0] mem_data_i
);

  localparam int unsigned PtrW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int unsigned CntW = $clog2(LINE_WORDS);
  localparam logic [CntW-1:0] LastWord = CntW'(LINE_WORDS - 1);
  localparam logic [PtrW:0]   FullCount = (PtrW + 1)'(DEPTH);

  typedef enum logic {StIdle, StBurst} state_e;

  state_e            state_q, state_d;
  logic [11:0]       fifo_q [DEPTH];
  logic [PtrW-1:0]   wr_ptr_q, rd_ptr_q;
  logic [PtrW:0]     count_q, count_d;
  logic [11:0]       line_q, line_d;
  logic [CntW-1:0]   cnt_q, cnt_d;
  logic              pending_q;
  logic              ready_q;
  logic [31:0]       data_q;

  logic push, q_empty, accept, line_done, want_line, take, pop, store;

  // Word offset bits of the request are irrelevant: lines always fill from word 0.
  logic unused_addr;
  assign unused_addr = ^addr_i[3:0];

  assign full_o     = (count_q == FullCount);
  assign mem_rd_o   = (state_q == StBurst);
  assign mem_addr_o = {line_q, cnt_q};
  assign ready_o    = ready_q;
  assign data_o     = data_q;

  // Queue control and FSM next state; an incoming request may bypass an empty
  // queue straight into the line register.
  always_comb begin
    push      = read_i & ~full_o;
    q_empty   = (count_q == '0);
    accept    = (state_q == StBurst) & ~mem_wait_i;
    line_done = accept & (cnt_q == LastWord);
    want_line = (state_q == StIdle) | line_done;
    take      = want_line & (~q_empty | push);
    pop       = take & ~q_empty;
    store     = push & ~(take & q_empty);

    state_d = state_q;
    line_d  = line_q;
    cnt_d   = cnt_q;
    count_d = count_q;

    if (accept) begin
      cnt_d = cnt_q + CntW'(1);
    end
    if (take) begin
      line_d  = q_empty ? addr_i[15:4] : fifo_q[rd_ptr_q];
      state_d = StBurst;
    end else if (line_done) begin
      state_d = StIdle;
    end

    unique case ({store, pop})
      2'b10:   count_d = count_q + (PtrW + 1)'(1);
      2'b01:   count_d = count_q - (PtrW + 1)'(1);
      default: count_d = count_q;
    endcase
  end

  // State, queue pointers and fill pipeline registers.
  always_ff @(posedge clock) begin
    if (reset) begin
      state_q   <= StIdle;
      wr_ptr_q  <= '0;
      rd_ptr_q  <= '0;
      count_q   <= '0;
      line_q    <= '0;
      cnt_q     <= '0;
      pending_q <= 1'b0;
      ready_q   <= 1'b0;
      data_q    <= '0;
    end else begin
      state_q   <= state_d;
      count_q   <= count_d;
      line_q    <= line_d;
      cnt_q     <= cnt_d;
      pending_q <= accept;
      ready_q   <= pending_q;
      if (store) wr_ptr_q <= wr_ptr_q + PtrW'(1);
      if (pop)   rd_ptr_q <= rd_ptr_q + PtrW'(1);
      if (pending_q) data_q <= mem_data_i;
    end
  end

  // Queue storage needs no reset; occupancy alone defines validity.
  always_ff @(posedge clock) begin
    if (store) fifo_q[wr_ptr_q] <= addr_i[15:4];
  end

endmodule

// File: tb/tb_ifill_server.sv
// Directed bench for ifill_server with a one-cycle-latency memory model and an
// in-order scoreboard of expected fill words.
module tb_ifill_server;

  logic        clock = 1'b0;
  logic        reset;
  logic        read_i;
  logic [15:0] addr_i;
  logic        full_o;
  logic        ready_o;
  logic [31:0] data_o;
  logic        mem_rd_o;
  logic [15:0] mem_addr_o;
  logic        mem_wait_i;
  logic [31:0] mem_data_i;

  int n_checks = 0;
  int n_fail   = 0;
  int ready_seen = 0;
  logic [31:0] exp_q[$];

  ifill_server #(.DEPTH(2), .LINE_WORDS(16)) dut (
    .clock      (clock),
    .reset      (reset),
    .read_i     (read_i),
    .addr_i     (addr_i),
    .full_o     (full_o),
    .ready_o    (ready_o),
    .data_o     (data_o),
    .mem_rd_o   (mem_rd_o),
    .mem_addr_o (mem_addr_o),
    .mem_wait_i (mem_wait_i),
    .mem_data_i (mem_data_i)
  );

  always #5 clock = ~clock;

  // Memory: word at address a holds 0x1000_0000 + a, returned one cycle after acceptance.
  always @(posedge clock) begin
    if (mem_rd_o && !mem_wait_i) mem_data_i <= 32'h1000_0000 + {16'h0, mem_addr_o};
  end

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // Scoreboard: every ready pulse must match the oldest outstanding expected word.
  always @(negedge clock) begin
    if (ready_o === 1'b1) begin
      ready_seen++;
      if (exp_q.size() == 0) begin
        check_eq("ready_expected", {31'b0, exp_q.size() != 0}, 32'd1);
      end else begin
        check_eq("fill_data", data_o, exp_q.pop_front());
      end
    end
    if (reset) exp_q.delete();
  end

  task automatic expect_line(input logic [15:0] a);
    for (int k = 0; k < 16; k++) exp_q.push_back(32'h1000_0000 + {16'h0, a[15:4], 4'(k)});
  endtask

  // Called at a negedge; drives a one-cycle request and returns at the next negedge.
  task automatic issue(input logic [15:0] a);
    read_i = 1'b1;
    addr_i = a;
    if (!full_o && !reset) expect_line(a);
    @(negedge clock);
    read_i = 1'b0;
  endtask

  task automatic measure_run(output int run);
    run = 0;
    while (ready_o && run < 100) begin
      run++;
      @(negedge clock);
    end
  endtask

  task automatic wait_idle(input string tag);
    int quiet = 0;
    int n = 0;
    while (quiet < 3 && n < 800) begin
      @(negedge clock);
      n++;
      if (!mem_rd_o && !ready_o) quiet++;
      else quiet = 0;
    end
    check_eq({tag, "_idle_timeout"}, {31'b0, quiet < 3}, 32'd0);
    check_eq({tag, "_drained"}, exp_q.size(), 32'd0);
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1);
  end

  initial begin
    int run, r0, n;
    logic found;

    reset = 1'b1; read_i = 1'b0; addr_i = '0; mem_wait_i = 1'b0;
    repeat (3) @(negedge clock);
    check_eq("rst_full", full_o, 0);
    check_eq("rst_ready", ready_o, 0);
    check_eq("rst_data", data_o, 0);
    check_eq("rst_mem_rd", mem_rd_o, 0);
    check_eq("rst_mem_addr", mem_addr_o, 0);
    reset = 1'b0;
    repeat (2) @(negedge clock);

    // Single fill: first ready three cycles after the request.
    r0 = ready_seen;
    issue(16'h1235);
    check_eq("single_rd", mem_rd_o, 1);
    check_eq("single_addr0", mem_addr_o, 16'h1230);
    @(negedge clock);
    check_eq("single_ready_t2", ready_o, 0);
    check_eq("single_addr1", mem_addr_o, 16'h1231);
    @(negedge clock);
    check_eq("single_ready_t3", ready_o, 1);
    measure_run(run);
    check_eq("single_run", run, 16);
    check_eq("single_rd_after", mem_rd_o, 0);
    wait_idle("single");
    check_eq("single_count", ready_seen - r0, 16);

    // Back-to-back lines give 32 contiguous pulses.
    issue(16'h0100);
    issue(16'h0200);
    @(negedge clock);
    check_eq("b2b_first", ready_o, 1);
    measure_run(run);
    check_eq("b2b_run", run, 32);
    wait_idle("b2b");

    // Overflow with DEPTH=2.
    r0 = ready_seen;
    issue(16'h0300);
    issue(16'h0400);
    check_eq("ovf_not_full", full_o, 0);
    issue(16'h0500);
    check_eq("ovf_full", full_o, 1);
    issue(16'h0600);
    found = 1'b0;
    for (int i = 0; i < 60 && !found; i++) begin
      if (!full_o) found = 1'b1;
      else @(negedge clock);
    end
    check_eq("ovf_slot_freed", found, 1);
    issue(16'h0700);
    wait_idle("ovf");
    check_eq("ovf_count", ready_seen - r0, 64);

    // Five-cycle stall at word 7.
    r0 = ready_seen;
    issue(16'h0800);
    found = 1'b0;
    for (int i = 0; i < 40 && !found; i++) begin
      if (mem_rd_o && mem_addr_o == 16'h0807) found = 1'b1;
      else @(negedge clock);
    end
    check_eq("stall_reach", found, 1);
    mem_wait_i = 1'b1;
    for (int i = 1; i <= 5; i++) begin
      @(negedge clock);
      check_eq("stall_addr", mem_addr_o, 16'h0807);
      check_eq("stall_rd", mem_rd_o, 1);
      check_eq("stall_ready", ready_o, (i == 1) ? 32'd1 : 32'd0);
    end
    mem_wait_i = 1'b0;
    @(negedge clock);
    check_eq("stall_gap_end", ready_o, 0);
    check_eq("stall_addr_next", mem_addr_o, 16'h0808);
    @(negedge clock);
    check_eq("stall_resume", ready_o, 1);
    wait_idle("stall");
    check_eq("stall_count", ready_seen - r0, 16);

    // Reset on the ninth ready pulse; a request seen during reset is ignored.
    issue(16'h0900);
    found = 1'b0;
    for (int i = 0; i < 10 && !found; i++) begin
      if (ready_o) found = 1'b1;
      else @(negedge clock);
    end
    check_eq("rstmid_start", found, 1);
    n = 1;
    while (n < 9) begin
      @(negedge clock);
      if (ready_o) n++;
    end
    reset = 1'b1;
    read_i = 1'b1;
    addr_i = 16'h0B00;
    @(negedge clock);
    check_eq("rstmid_ready", ready_o, 0);
    check_eq("rstmid_full", full_o, 0);
    check_eq("rstmid_rd", mem_rd_o, 0);
    check_eq("rstmid_data", data_o, 0);
    check_eq("rstmid_addr", mem_addr_o, 0);
    @(negedge clock);
    reset = 1'b0;
    read_i = 1'b0;
    repeat (3) @(negedge clock);
    check_eq("rstmid_ignored", mem_rd_o, 0);
    check_eq("rstmid_noready", ready_o, 0);
    r0 = ready_seen;
    issue(16'h0A35);
    check_eq("rstmid_new_addr", mem_addr_o, 16'h0A30);
    wait_idle("rstmid");
    check_eq("rstmid_count", ready_seen - r0, 16);

    // Random soak, then drain.
    for (int c = 0; c < 2000; c++) begin
      read_i = ($urandom_range(7) == 0);
      addr_i = 16'($urandom);
      mem_wait_i = ($urandom_range(3) == 0);
      if (read_i && !full_o) expect_line(addr_i);
      @(negedge clock);
    end
    read_i = 1'b0;
    mem_wait_i = 1'b0;
    wait_idle("soak");

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/ifill_server.md
IFILL_SERVER -- requirements
Module: ifill_server

Interface
REQ-001 Parameter DEPTH, default 2: number of line requests the queue holds (2 or 4).
REQ-002 Parameter LINE_WORDS, default 16: words per cache line; fixed at 16, and the 4-bit word counter depends on it.
REQ-003 clock  input  1  rising-edge system clock.
REQ-004 reset  input  1  reset, synchronous, active-high.
REQ-005 read_i  input  1  line-fill request strobe from the instruction cache; one cycle per request.
REQ-006 addr_i  input  16  word address of the request; only addr_i[15:4] (line number) is used.
REQ-007 full_o  output  1  request queue full; read_i is ignored while high.
REQ-008 ready_o  output  1  data_o holds a valid fill word this cycle.
REQ-009 data_o  output  32  fill word.
REQ-010 mem_rd_o  output  1  backing-memory read strobe.
REQ-011 mem_addr_o  output  16  backing-memory word address.
REQ-012 mem_wait_i  input  1  memory stall; a read is accepted only when mem_rd_o=1 and mem_wait_i=0.
REQ-013 mem_data_i  input  32  memory read data, valid exactly 1 cycle after an accepted read.

Function
REQ-014 Request queue: FIFO of DEPTH line numbers; push when read_i=1 and full_o=0; full_o = (occupancy == DEPTH), combinational from occupancy.
REQ-015 read_i while full_o=1 is dropped, even if a pop occurs the same cycle.
REQ-016 Push and pop in the same cycle leave occupancy unchanged.
REQ-017 FSM states IDLE and BURST; IDLE->BURST when the queue is non-empty; the head entry is popped into the line register on that transition.
REQ-018 In BURST: mem_rd_o=1, mem_addr_o={line, cnt}; cnt starts at 0 and increments by 1 per accepted read.
REQ-019 mem_wait_i=1 holds cnt, mem_addr_o and mem_rd_o steady.
REQ-020 On the accepted read with cnt=15: if the queue is non-empty, pop the next line and stay in BURST with cnt=0 the next cycle (no bubble); otherwise go to IDLE.
REQ-021 Words are always delivered from word 0 to word 15 regardless of addr_i[3:0]; there is no critical-word-first ordering.
REQ-022 The cycle after an accepted read, mem_data_i is registered into data_o and ready_o=1 the following cycle. Latency from accepted read to ready_o is 2 cycles.
REQ-023 Each request yields exactly 16 ready_o pulses, in request order. Bursts never interleave.
REQ-024 Fastest case: read_i in cycle T with an empty queue and IDLE, and mem_wait_i=0 gives the first ready_o in cycle T+3. Cycle T+1 is the transition to BURST; ready_o then pulses for 16 consecutive cycles.
REQ-025 data_o retains its last value when ready_o=0.
REQ-026 mem_rd_o=0 in IDLE.

Reset
REQ-027 While reset=1 at a clock edge, every output returns to its reset value: FSM->IDLE, cnt=0, queue emptied, full_o=0, ready_o=0, data_o=0, mem_rd_o=0, mem_addr_o=0.
REQ-028 Reset mid-burst abandons the burst; the in-flight memory word is discarded, and ready_o=0 from the first cycle after reset.
REQ-029 read_i sampled during reset is ignored.

Verification
REQ-030 Single fill: memory word k = 0x1000_0000+k, mem_wait_i=0, read_i with addr_i=0x1235 -> mem_addr_o 0x1230..0x123F, then 16 ready_o pulses with data_o = data at 0x1230..0x123F in order, first pulse 3 cycles after read_i.
REQ-031 Back-to-back: requests for lines 0x010 and 0x020 one cycle apart -> 32 consecutive ready_o pulses with no gap; words 0x0100..0x010F then 0x0200..0x020F.
REQ-032 Overflow, DEPTH=2: three read_i while the first burst runs and two are queued -> full_o=1 after the second queued push, and the third request is never served. A later request after a slot frees is served normally.
REQ-033 Stall: mem_wait_i=1 for 5 cycles at cnt=7 -> mem_addr_o holds {line,7} and ready_o has a matching 5-cycle gap; all 16 words are still delivered correctly.
REQ-034 Reset at ready pulse 9 -> ready_o=0 next cycle, full_o=0, mem_rd_o=0. A new request after reset returns a clean 16-word burst from word 0.
REQ-035 Random soak: random read_i, mem_wait_i and addresses for 20000 ns -> a scoreboard confirms every accepted request returns 16 words in order and that no dropped request produces data.
